// File: rtl/distortion_pkg.sv
// Shared types and limits for the multi-channel threshold distortion.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: mode_e (shaping mode), state_e (frame FSM), sat_max/sat_min (signed range of a width).
package distortion_pkg;

  typedef enum logic [1:0] {
    MODE_BOOST = 2'd0,
    MODE_HARD  = 2'd1,
    MODE_SOFT  = 2'd2,
    MODE_ASYM  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAIN  = 2'd1,
    ST_SHAPE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Signed limits of a dw-bit two's complement value (dw <= 63).
  function automatic logic signed [63:0] sat_max(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/distortion_shaper.sv
// Combinational shaping stage: maps a gained sample to boost/hard/soft/asym output plus clip flag.
// Latency: 0 cycles (pure combinational, registered by the caller).
// Backpressure: none; evaluated every cycle, consumed only in the SHAPE state.
// Ports: g_i gained sample, thr_i threshold magnitude, mode_i shaping mode,
//        sat_i gain-stage saturated, out_o shaped sample, flag_o clip flag.
module distortion_shaper
  import distortion_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KNEE_SHIFT = 2
) (
  input  logic signed [DATA_WIDTH-1:0] g_i,
  input  logic        [DATA_WIDTH-2:0] thr_i,
  input  mode_e                        mode_i,
  input  logic                         sat_i,
  output logic signed [DATA_WIDTH-1:0] out_o,
  output logic                         flag_o
);

  // One extra bit so |most-negative| is representable.
  localparam int MW = DATA_WIDTH + 1;
  localparam logic [MW-1:0] MAG_MAX = MW'(sat_max(DATA_WIDTH));

  logic          neg;
  logic [MW-1:0] g_ext;
  logic [MW-1:0] mag;
  logic [MW-1:0] t_ext;
  logic [MW-1:0] knee;
  logic [MW-1:0] mag_out;
  logic [MW-1:0] res;
  logic          over;
  logic          use_knee;

  assign neg      = g_i[DATA_WIDTH-1];
  assign g_ext    = {g_i[DATA_WIDTH-1], g_i};
  assign mag      = neg ? (~g_ext + MW'(1)) : g_ext;
  assign t_ext    = {2'b00, thr_i};
  assign over     = mag > t_ext;
  assign knee     = t_ext + ((mag - t_ext) >> KNEE_SHIFT);
  // Asym mode clips hard on the positive half and bends softly on the negative half.
  assign use_knee = (mode_i == MODE_SOFT) || ((mode_i == MODE_ASYM) && neg);
  assign mag_out  = use_knee ? ((knee > MAG_MAX) ? MAG_MAX : knee) : t_ext;
  assign res      = neg ? (~mag_out + MW'(1)) : mag_out;

  always_comb begin
    out_o  = g_i;
    flag_o = 1'b0;
    if (mode_i == MODE_BOOST) begin
      flag_o = sat_i;
    end else if (over) begin
      out_o  = res[DATA_WIDTH-1:0];
      flag_o = 1'b1;
    end
  end

endmodule

// File: rtl/distortion_multi.sv
// Multi-channel threshold distortion: per-frame saturating pre-gain then shared shaper, channel by channel.
// Latency: y/y_valid after edge t+2*CHANNELS+1 for a strobe sampled at edge t; en=0 gives 1-cycle registered bypass.
// Backpressure: none; audio_ready while busy or in DONE drops the frame (counted when DISTORTION_OVERRUN_CNT_EN is defined).
// Ports: CLK, rst (sync, active high), en, audio_ready, x (frame), threshold, gain, mode,
//        y (frame), y_valid, busy, indicator (per-channel clip), overrun_cnt (only with DISTORTION_OVERRUN_CNT_EN).
module distortion_multi
  import distortion_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_FRAC  = 4,
  parameter int KNEE_SHIFT = 2
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           audio_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH-1:0]          threshold,
  input  logic [GAIN_WIDTH-1:0]          gain,
  input  logic [1:0]                     mode,
  output logic [CHANNELS*DATA_WIDTH-1:0] y,
  output logic                           y_valid,
  output logic                           busy,
  output logic [CHANNELS-1:0]            indicator
`ifdef DISTORTION_OVERRUN_CNT_EN
  ,output logic [15:0]                   overrun_cnt
`endif
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam logic signed [PW-1:0] P_MAX = PW'(sat_max(DATA_WIDTH));
  localparam logic signed [PW-1:0] P_MIN = PW'(sat_min(DATA_WIDTH));

  state_e                           state_q;
  logic [CW-1:0]                    ch_q;
  logic [CHANNELS*DATA_WIDTH-1:0]   x_q;
  logic [GAIN_WIDTH-1:0]            gain_q;
  mode_e                            mode_q;
  logic [DATA_WIDTH-2:0]            thr_q;
  logic signed [DATA_WIDTH-1:0]     g_q;
  logic                             sat_q;
  logic [CHANNELS*DATA_WIDTH-1:0]   ybuf_q;
  logic [CHANNELS-1:0]              fbuf_q;
  logic [CHANNELS*DATA_WIDTH-1:0]   y_q;
  logic                             y_valid_q;
  logic                             busy_q;
  logic [CHANNELS-1:0]              ind_q;

  // Threshold is a magnitude; its sign bit carries no meaning.
  logic unused_thr_msb;
  assign unused_thr_msb = threshold[DATA_WIDTH-1];

  // Gain stage: signed multiply by unsigned gain, arithmetic shift, saturate.
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic signed [PW-1:0]         p_d;
  logic signed [PW-1:0]         p_sh;
  logic signed [DATA_WIDTH-1:0] g_d;
  logic                         sat_d;

  assign x_cur = x_q[ch_q*DATA_WIDTH +: DATA_WIDTH];
  assign p_d   = PW'(x_cur) * PW'($signed({1'b0, gain_q}));
  assign p_sh  = p_d >>> GAIN_FRAC;

  always_comb begin
    g_d   = p_sh[DATA_WIDTH-1:0];
    sat_d = 1'b0;
    if (p_sh > P_MAX) begin
      g_d   = P_MAX[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end else if (p_sh < P_MIN) begin
      g_d   = P_MIN[DATA_WIDTH-1:0];
      sat_d = 1'b1;
    end
  end

  logic signed [DATA_WIDTH-1:0] shp_out_d;
  logic                         shp_flag_d;

  distortion_shaper #(
    .DATA_WIDTH (DATA_WIDTH),
    .KNEE_SHIFT (KNEE_SHIFT)
  ) u_shaper (
    .g_i    (g_q),
    .thr_i  (thr_q),
    .mode_i (mode_q),
    .sat_i  (sat_q),
    .out_o  (shp_out_d),
    .flag_o (shp_flag_d)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      x_q       <= '0;
      gain_q    <= '0;
      mode_q    <= MODE_BOOST;
      thr_q     <= '0;
      g_q       <= '0;
      sat_q     <= 1'b0;
      ybuf_q    <= '0;
      fbuf_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      ind_q     <= '0;
    end else if (!en) begin
      // Bypass: abandon any frame in flight and pass input straight through.
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      busy_q    <= 1'b0;
      ind_q     <= '0;
      y_q       <= x;
      y_valid_q <= audio_ready;
    end else begin
      y_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (audio_ready) begin
            x_q     <= x;
            gain_q  <= gain;
            mode_q  <= mode_e'(mode);
            thr_q   <= threshold[DATA_WIDTH-2:0];
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_GAIN;
          end
        end
        ST_GAIN: begin
          g_q     <= g_d;
          sat_q   <= sat_d;
          state_q <= ST_SHAPE;
        end
        ST_SHAPE: begin
          ybuf_q[ch_q*DATA_WIDTH +: DATA_WIDTH] <= shp_out_d;
          fbuf_q[ch_q]                           <= shp_flag_d;
          if (ch_q == CW'(CHANNELS - 1)) begin
            state_q <= ST_DONE;
          end else begin
            ch_q    <= ch_q + CW'(1);
            state_q <= ST_GAIN;
          end
        end
        ST_DONE: begin
          y_q       <= ybuf_q;
          ind_q     <= fbuf_q;
          y_valid_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DISTORTION_OVERRUN_CNT_EN
  logic [15:0] ovr_q;

  // Any strobe outside IDLE (busy or DONE) with the effect enabled is a dropped frame.
  always_ff @(posedge CLK) begin
    if (rst) begin
      ovr_q <= '0;
    end else if (en && audio_ready && (state_q != ST_IDLE) && (ovr_q != 16'hFFFF)) begin
      ovr_q <= ovr_q + 16'd1;
    end
  end

  assign overrun_cnt = ovr_q;
`endif

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign busy      = busy_q;
  assign indicator = ind_q;

endmodule

// File: tb/tb_distortion_multi.sv
// Self-checking bench for distortion_multi (2 channels x 32 bits, Q4.4 gain).
// Latency: expects y_valid 5 cycles after an accepted strobe.
// Backpressure: exercises dropped strobes while busy / in DONE and the en=0 bypass.
module tb_distortion_multi;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        audio_ready = 1'b0;
  logic [63:0] x = '0;
  logic [31:0] threshold = '0;
  logic [7:0]  gain = '0;
  logic [1:0]  mode = '0;
  wire  [63:0] y;
  wire         y_valid;
  wire         busy;
  wire  [1:0]  indicator;
`ifdef DISTORTION_OVERRUN_CNT_EN
  wire  [15:0] overrun_cnt;
`endif

  int total = 0;
  int bad   = 0;

  distortion_multi #(
    .DATA_WIDTH (32),
    .CHANNELS   (2),
    .GAIN_WIDTH (8),
    .GAIN_FRAC  (4),
    .KNEE_SHIFT (2)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .en          (en),
    .audio_ready (audio_ready),
    .x           (x),
    .threshold   (threshold),
    .gain        (gain),
    .mode        (mode),
    .y           (y),
    .y_valid     (y_valid),
    .busy        (busy),
    .indicator   (indicator)
`ifdef DISTORTION_OVERRUN_CNT_EN
    ,.overrun_cnt (overrun_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  localparam longint MAXV = 64'sh7FFFFFFF;
  localparam longint MINV = -64'sh80000000;

  // Reference: gain in Q4.4 with saturation, then threshold shaping on plain integers.
  function automatic void model(input logic [31:0] xv, input logic [7:0] gv, input logic [1:0] md,
                                input logic [31:0] th, output logic [31:0] o, output logic f);
    longint g, t, m, r;
    bit s;
    g = longint'($signed(xv)) * longint'(gv);
    g = g >>> 4;
    s = 0;
    if (g > MAXV) begin g = MAXV; s = 1; end
    if (g < MINV) begin g = MINV; s = 1; end
    t = longint'(th & 32'h7FFFFFFF);
    m = (g < 0) ? -g : g;
    if (md == 2'd0) begin
      o = g[31:0];
      f = s;
    end else if (m > t) begin
      if (md == 2'd1 || (md == 2'd3 && g > 0)) r = t;
      else begin
        r = t + ((m - t) >> 2);
        if (r > MAXV) r = MAXV;
      end
      r = (g < 0) ? -r : r;
      o = r[31:0];
      f = 1'b1;
    end else begin
      o = g[31:0];
      f = 1'b0;
    end
  endfunction

  task automatic run_frame(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                           input logic [7:0] gv, input logic [1:0] md, input logic [31:0] th);
    logic [31:0] e0, e1;
    logic        f0, f1;
    int          cnt;
    model(x0, gv, md, th, e0, f0);
    model(x1, gv, md, th, e1, f1);
    x = {x1, x0}; gain = gv; mode = md; threshold = th; audio_ready = 1'b1;
    tick;
    chk({tag, "_busy"}, busy, 1);
    // Scramble the live inputs: the captured copies must be used.
    audio_ready = 1'b0;
    x = {$urandom, $urandom}; gain = 8'($urandom); mode = 2'($urandom); threshold = $urandom;
    cnt = 0;
    while (!y_valid && cnt < 20) begin
      tick;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 5);
    chk({tag, "_y0"}, y[31:0], e0);
    chk({tag, "_y1"}, y[63:32], e1);
    chk({tag, "_ind"}, indicator, {f1, f0});
    tick;
    chk({tag, "_vld_pulse"}, y_valid, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int          pulses;
    logic [63:0] ycap;
    logic [31:0] ea, eb;
    logic        fa, fb;
    logic        ar;

    // Reset with live strobes and data.
    rst = 1'b1; en = 1'b1; audio_ready = 1'b1; x = {$urandom, $urandom}; mode = 2'd1; gain = 8'h10;
    tick;
    x = {$urandom, $urandom};
    tick;
    chk("rst_y", y, 0);
    chk("rst_vld", y_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ind", indicator, 0);
`ifdef DISTORTION_OVERRUN_CNT_EN
    chk("rst_ovr", overrun_cnt, 0);
`endif
    rst = 1'b0; audio_ready = 1'b0;
    tick;

    // Directed frames.
    run_frame("hard", 32'h01000000, 32'hFF000000, 8'h10, 2'd1, 32'h00C00000);
    chk("hard_exp_y", y, {32'hFF400000, 32'h00C00000} ^ 64'h0) ;
    run_frame("soft", 32'h01000000, 32'h00100000, 8'h10, 2'd2, 32'h00C00000);
    run_frame("gsat", 32'h7FFFFFFF, 32'h80000000, 8'hFF, 2'd0, 32'h00C00000);
    run_frame("unity", 32'h00000005, 32'hFFFFFFFB, 8'h10, 2'd0, 32'h00C00000);
    run_frame("asym", 32'h01000000, 32'hFF000000, 8'h10, 2'd3, 32'h80C00000);

    // Bypass / abort mid-frame.
    x = {$urandom, $urandom}; mode = 2'd1; gain = 8'h10; threshold = 32'h100; audio_ready = 1'b1;
    tick;
    audio_ready = 1'b0;
    tick;
    en = 1'b0; x = {$urandom, $urandom};
    tick;
    chk("abort_busy", busy, 0);
    chk("abort_y", y, x);
    chk("abort_vld", y_valid, 0);
    chk("abort_ind", indicator, 0);
    for (int i = 0; i < 6; i++) begin
      ar = 1'($urandom);
      x = {$urandom, $urandom}; audio_ready = ar;
      tick;
      chk("byp_y", y, x);
      chk("byp_vld", y_valid, ar);
      chk("byp_busy", busy, 0);
    end
    en = 1'b1; audio_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (y_valid) pulses++;
    end
    chk("abort_no_vld", pulses, 0);

    // Strobes on three consecutive cycles: only the first frame is processed.
    model(32'h00400000, 8'h20, 2'd2, 32'h00300000, ea, fa);
    model(32'hFFA00000, 8'h20, 2'd2, 32'h00300000, eb, fb);
    x = {32'hFFA00000, 32'h00400000}; gain = 8'h20; mode = 2'd2; threshold = 32'h00300000;
    audio_ready = 1'b1;
    tick;
    x = {$urandom, $urandom};
    tick;
    x = {$urandom, $urandom};
    tick;
    audio_ready = 1'b0;
    pulses = 0; ycap = '0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (y_valid) begin pulses++; ycap = y; end
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_y", ycap, {eb, ea});
    chk("ovr_ind", indicator, {fb, fa});
`ifdef DISTORTION_OVERRUN_CNT_EN
    chk("ovr_cnt", overrun_cnt, 2);
`endif

    // Strobe landing in DONE is dropped too.
    x = {32'h00000100, 32'h00000200}; gain = 8'h10; mode = 2'd0; audio_ready = 1'b1;
    tick;
    audio_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    audio_ready = 1'b1; x = {$urandom, $urandom};
    tick;
    chk("done_vld", y_valid, 1);
    chk("done_y", y, {32'h00000100, 32'h00000200});
    audio_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (y_valid) pulses++;
    end
    chk("done_drop", pulses, 0);
`ifdef DISTORTION_OVERRUN_CNT_EN
    chk("done_ovr_cnt", overrun_cnt, 3);
`endif

    // Randomised frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rx0, rx1;
      rx0 = 32'($signed($urandom) >>> $urandom_range(0, 12));
      rx1 = 32'($signed($urandom) >>> $urandom_range(0, 12));
      run_frame("rand", rx0, rx1, 8'($urandom), 2'($urandom), $urandom >> $urandom_range(0, 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
